// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: FSM states and read-owner encoding.
package core_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Fetch starvation guard: counts data grants taken while fetch waits and raises force_fetch
// at STARVE_MAX. Only present when MEM_ARB_STARVE_GUARD_EN is defined.
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_fetch
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // Saturates at STARVE_MAX so the fetch side keeps its claim until it is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (if_gnt || !if_req) begin
      cnt <= '0;
    end else if (d_gnt && (cnt != CW'(STARVE_MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign force_fetch = if_req && (cnt == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store requesters,
// data first, one read outstanding. Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t       state, state_nxt;
  arb_owner_t       owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             resp, can_grant, force_fetch, rd_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_gnt      (if_gnt),
    .d_gnt       (d_gnt),
    .force_fetch (force_fetch)
  );
`else
  logic unused_starve_max;
  assign force_fetch       = 1'b0;
  assign unused_starve_max = (STARVE_MAX != 0);
`endif

  // The response cycle frees the port, so a new grant may overlap it.
  assign resp      = (state == WAIT) && (cnt == '0);
  assign can_grant = rst_n && ((state == IDLE) || resp);

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (can_grant) begin
      if (d_req && !force_fetch) begin
        d_gnt     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_we ? d_wdata : '0;
        mem_be    = d_we ? d_be : '1;
      end else if (if_req) begin
        if_gnt   = 1'b1;
        mem_req  = 1'b1;
        mem_addr = if_addr;
        mem_be   = '1;
      end
    end
  end

  always_comb begin
    if_rvalid = resp && (owner == OWN_FETCH);
    d_rvalid  = resp && (owner == OWN_DATA);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

  assign rd_gnt = if_gnt || (d_gnt && !d_we);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    if (rd_gnt) begin
      state_nxt = WAIT;
      owner_nxt = d_gnt ? OWN_DATA : OWN_FETCH;
      cnt_nxt   = CNT_W'(RD_LAT - 1);
    end else if (resp) begin
      state_nxt = IDLE;
    end else if (state == WAIT) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
